// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory arbiter.
//   state_t        : arbiter FSM encoding (IDLE, MEM, DONE)
//   PORT_I/PORT_D  : grant indices for the I-cache and D-cache
//   PHYS_ADDR_SIZE : default physical address width
//   LINE_WIDTH     : default cache line width in bits
// Optional feature macro used by the arbiter: MEM_ARB_DCACHE_PRIORITY_EN.
package mem_arb_pkg;
    localparam int PHYS_ADDR_SIZE = 32;
    localparam int LINE_WIDTH = 128;
    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;
    typedef enum logic [1:0] {IDLE, MEM, DONE} state_t;
endpackage

// File: rtl/mem_arb_picker.sv
// mem_arb_picker: combinational winner selection between the I-cache and D-cache.
//   req_i, req_d : per-cache request bits
//   last_grant   : index of the previous grant
//   grant        : index of the winning cache (PORT_I when neither requests)
// Macro MEM_ARB_DCACHE_PRIORITY_EN: defined selects fixed D-cache priority,
// undefined selects round-robin.
module mem_arb_picker
    import mem_arb_pkg::*;
(
    input  logic req_i,
    input  logic req_d,
    input  logic last_grant,
    output logic grant
);
`ifdef MEM_ARB_DCACHE_PRIORITY_EN
    // last_grant has no role under fixed priority
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
    always_comb grant = req_d ? PORT_D : PORT_I;
`else
    // on a tie the cache not granted last wins
    always_comb grant = (req_i && req_d) ? (last_grant == PORT_I ? PORT_D : PORT_I)
                                         : (req_d ? PORT_D : PORT_I);
`endif
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the main-memory port between the I-cache and D-cache.
//   clock, reset_n                : clock (rising edge), async active-low reset
//   i_/d_cache_miss               : line fill request per cache (level)
//   i_/d_write_to_memory          : dirty-line write-back request per cache (level)
//   i_/d_address, i_/d_out_data   : line address and write-back data per cache
//   i_/d_from_memory_write_enable : one-cycle fill-done pulse per cache
//   i_/d_completed_write_to_memory: one-cycle write-back-done pulse per cache
//   from_memory_input_data        : last filled line, shared by both caches
//   mem_req/mem_write/mem_addr/mem_wdata : memory request, held until mem_ack
//   mem_ack, mem_rdata            : memory completion pulse and fill data
//   busy                          : high while a transaction is in flight
// Macro MEM_ARB_DCACHE_PRIORITY_EN selects fixed D-cache priority on ties
// (default: round-robin).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_SIZE  = PHYS_ADDR_SIZE,
    parameter int LINE_WIDTH = mem_arb_pkg::LINE_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  i_cache_miss,
    input  logic                  i_write_to_memory,
    input  logic [ADDR_SIZE-1:0]  i_address,
    input  logic [LINE_WIDTH-1:0] i_out_data,
    input  logic                  d_cache_miss,
    input  logic                  d_write_to_memory,
    input  logic [ADDR_SIZE-1:0]  d_address,
    input  logic [LINE_WIDTH-1:0] d_out_data,
    output logic                  i_from_memory_write_enable,
    output logic                  d_from_memory_write_enable,
    output logic                  i_completed_write_to_memory,
    output logic                  d_completed_write_to_memory,
    output logic [LINE_WIDTH-1:0] from_memory_input_data,
    output logic                  mem_req,
    output logic                  mem_write,
    output logic [ADDR_SIZE-1:0]  mem_addr,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    output logic                  busy
);
    state_t state;
    logic   grant;
    logic   last_grant;
    logic   pick;
    logic   req_i;
    logic   req_d;

    assign req_i = i_cache_miss | i_write_to_memory;
    assign req_d = d_cache_miss | d_write_to_memory;

    mem_arb_picker u_picker (
        .req_i      (req_i),
        .req_d      (req_d),
        .last_grant (last_grant),
        .grant      (pick)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state                       <= IDLE;
            grant                       <= PORT_I;
            last_grant                  <= PORT_D;
            mem_req                     <= 1'b0;
            mem_write                   <= 1'b0;
            mem_addr                    <= '0;
            mem_wdata                   <= '0;
            from_memory_input_data      <= '0;
            busy                        <= 1'b0;
            i_from_memory_write_enable  <= 1'b0;
            d_from_memory_write_enable  <= 1'b0;
            i_completed_write_to_memory <= 1'b0;
            d_completed_write_to_memory <= 1'b0;
        end else begin
            i_from_memory_write_enable  <= 1'b0;
            d_from_memory_write_enable  <= 1'b0;
            i_completed_write_to_memory <= 1'b0;
            d_completed_write_to_memory <= 1'b0;
            case (state)
                IDLE: if (req_i || req_d) begin
                    state      <= MEM;
                    grant      <= pick;
                    last_grant <= pick;
                    mem_req    <= 1'b1;
                    busy       <= 1'b1;
                    mem_write  <= pick == PORT_D ? d_write_to_memory : i_write_to_memory;
                    mem_addr   <= pick == PORT_D ? d_address : i_address;
                    mem_wdata  <= pick == PORT_D ? d_out_data : i_out_data;
                end
                MEM: if (mem_ack) begin
                    state   <= DONE;
                    mem_req <= 1'b0;
                    if (mem_write) begin
                        i_completed_write_to_memory <= grant == PORT_I;
                        d_completed_write_to_memory <= grant == PORT_D;
                    end else begin
                        from_memory_input_data     <= mem_rdata;
                        i_from_memory_write_enable <= grant == PORT_I;
                        d_from_memory_write_enable <= grant == PORT_D;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed, table-driven bench for mem_arbiter.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

`ifdef MEM_ARB_DCACHE_PRIORITY_EN
    localparam bit DPRI = 1'b1;
`else
    localparam bit DPRI = 1'b0;
`endif

    typedef struct {
        logic         i_miss;
        logic         i_wr;
        logic [31:0]  i_addr;
        logic [127:0] i_data;
        logic         d_miss;
        logic         d_wr;
        logic [31:0]  d_addr;
        logic [127:0] d_data;
        int           delay;
        logic [127:0] rdata;
        logic         tie;
        logic         port;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         i_cache_miss = 1'b0, i_write_to_memory = 1'b0;
    logic [31:0]  i_address = '0;
    logic [127:0] i_out_data = '0;
    logic         d_cache_miss = 1'b0, d_write_to_memory = 1'b0;
    logic [31:0]  d_address = '0;
    logic [127:0] d_out_data = '0;
    logic         i_from_memory_write_enable, d_from_memory_write_enable;
    logic         i_completed_write_to_memory, d_completed_write_to_memory;
    logic [127:0] from_memory_input_data;
    logic         mem_req, mem_write;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic         mem_ack = 1'b0;
    logic [127:0] mem_rdata = '0;
    logic         busy;

    int checks = 0;
    int errors = 0;
    logic [127:0] last_fill = '0;
    vec_t vecs[7];

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clock                       (clk),
        .reset_n                     (reset_n),
        .i_cache_miss                (i_cache_miss),
        .i_write_to_memory           (i_write_to_memory),
        .i_address                   (i_address),
        .i_out_data                  (i_out_data),
        .d_cache_miss                (d_cache_miss),
        .d_write_to_memory           (d_write_to_memory),
        .d_address                   (d_address),
        .d_out_data                  (d_out_data),
        .i_from_memory_write_enable  (i_from_memory_write_enable),
        .d_from_memory_write_enable  (d_from_memory_write_enable),
        .i_completed_write_to_memory (i_completed_write_to_memory),
        .d_completed_write_to_memory (d_completed_write_to_memory),
        .from_memory_input_data      (from_memory_input_data),
        .mem_req                     (mem_req),
        .mem_write                   (mem_write),
        .mem_addr                    (mem_addr),
        .mem_wdata                   (mem_wdata),
        .mem_ack                     (mem_ack),
        .mem_rdata                   (mem_rdata),
        .busy                        (busy)
    );

    function automatic logic [3:0] pulses();
        return {i_from_memory_write_enable, d_from_memory_write_enable,
                i_completed_write_to_memory, d_completed_write_to_memory};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_req(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_req && n < 8);
    endtask

    task automatic clear_inputs();
        i_cache_miss = 1'b0; i_write_to_memory = 1'b0;
        d_cache_miss = 1'b0; d_write_to_memory = 1'b0;
    endtask

    // Called at a negedge: drive the record, run one transaction, end at the
    // negedge of the first IDLE cycle after the done pulse.
    task automatic run_txn(input vec_t v);
        logic         p, wr;
        logic [31:0]  ea;
        logic [127:0] ew;
        logic [3:0]   ep;
        int           n;
        p  = (v.tie && DPRI) ? PORT_D : v.port;
        wr = p ? v.d_wr : v.i_wr;
        ea = p ? v.d_addr : v.i_addr;
        ew = p ? v.d_data : v.i_data;
        ep = wr ? (p ? 4'b0001 : 4'b0010) : (p ? 4'b0100 : 4'b1000);
        i_cache_miss = v.i_miss; i_write_to_memory = v.i_wr;
        i_address = v.i_addr; i_out_data = v.i_data;
        d_cache_miss = v.d_miss; d_write_to_memory = v.d_wr;
        d_address = v.d_addr; d_out_data = v.d_data;
        wait_req(n);
        check("req_latency", 128'(n), 128'(1));
        check("mem_addr", 128'(mem_addr), 128'(ea));
        check("mem_write", 128'(mem_write), 128'(wr));
        if (wr) check("mem_wdata", mem_wdata, ew);
        check("busy_mem", 128'(busy), 128'(1));
        repeat (v.delay) @(negedge clk);
        check("mem_req_held", 128'(mem_req), 128'(1));
        check("mem_addr_stable", 128'(mem_addr), 128'(ea));
        mem_ack = 1'b1; mem_rdata = v.rdata;
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = '0;
        if (!wr) last_fill = v.rdata;
        check("mem_req_drop", 128'(mem_req), 128'(0));
        check("done_pulse", 128'(pulses()), 128'(ep));
        check("fill_data", from_memory_input_data, last_fill);
        if (p) begin d_cache_miss = 1'b0; d_write_to_memory = 1'b0; end
        else begin i_cache_miss = 1'b0; i_write_to_memory = 1'b0; end
        @(negedge clk);
        check("pulse_clear", 128'(pulses()), 128'(0));
        check("busy_idle", 128'(busy), 128'(0));
    endtask

    initial begin
        int n;
        //          i_miss i_wr i_addr      i_data     d_miss d_wr d_addr      d_data     dly rdata      tie  port
        vecs[0] = '{1'b1, 1'b0, 32'h1000, 128'h0,    1'b0, 1'b0, 32'h0,    128'h0,    2, 128'hCAFE, 1'b0, PORT_I};
        vecs[1] = '{1'b0, 1'b0, 32'h0,    128'h0,    1'b0, 1'b1, 32'h2000, 128'hBEEF, 1, 128'h0,    1'b0, PORT_D};
        vecs[2] = '{1'b0, 1'b0, 32'h0,    128'h0,    1'b1, 1'b0, 32'h2000, 128'h0,    0, 128'h1234, 1'b0, PORT_D};
        vecs[3] = '{1'b1, 1'b0, 32'h3000, 128'h0,    1'b0, 1'b1, 32'h4000, 128'h5555, 0, 128'h1111, 1'b1, PORT_I};
        vecs[4] = '{1'b1, 1'b0, 32'h3040, 128'h0,    1'b0, 1'b1, 32'h4000, 128'h5555, 1, 128'h2222, 1'b1, PORT_D};
        vecs[5] = '{1'b1, 1'b0, 32'h3040, 128'h0,    1'b1, 1'b0, 32'h4040, 128'h0,    0, 128'h3333, 1'b1, PORT_I};
        vecs[6] = '{1'b0, 1'b1, 32'h3080, 128'h7777, 1'b1, 1'b0, 32'h4040, 128'h0,    2, 128'h4444, 1'b1, PORT_D};

        repeat (2) @(negedge clk);
        check("rst_mem_req", 128'(mem_req), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_pulses", 128'(pulses()), 128'(0));
        check("rst_fill_data", from_memory_input_data, 128'(0));
        check("rst_mem_addr", 128'(mem_addr), 128'(0));
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_no_req", 128'(mem_req), 128'(0));

        for (int k = 0; k < 7; k++) run_txn(vecs[k]);
        clear_inputs();

        // request withdrawn during MEM still completes, no second grant
        i_cache_miss = 1'b1; i_address = 32'h5000;
        wait_req(n);
        check("drop_req_latency", 128'(n), 128'(1));
        i_cache_miss = 1'b0;
        repeat (2) @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 128'hABCD;
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = '0;
        check("drop_pulse", 128'(pulses()), 128'(4'b1000));
        check("drop_data", from_memory_input_data, 128'hABCD);
        repeat (3) begin
            @(negedge clk);
            check("drop_no_regrant", 128'({mem_req, busy}), 128'(0));
        end

        // reset in MEM aborts; last_grant returns to D so I wins the next tie
        i_cache_miss = 1'b1; i_address = 32'h6000;
        wait_req(n);
        check("abort_req", 128'(mem_req), 128'(1));
        reset_n = 1'b0;
        #1;
        check("abort_mem_req", 128'(mem_req), 128'(0));
        check("abort_busy", 128'(busy), 128'(0));
        clear_inputs();
        last_fill = '0;
        @(negedge clk);
        check("abort_no_pulse", 128'(pulses()), 128'(0));
        reset_n = 1'b1;
        @(negedge clk);
        check("abort_idle", 128'({mem_req, busy, pulses()}), 128'(0));
        run_txn('{1'b1, 1'b0, 32'h7000, 128'h0, 1'b1, 1'b0, 32'h7100, 128'h0, 1, 128'h9999, 1'b1, PORT_I});
        clear_inputs();
        repeat (2) @(negedge clk);
        check("final_idle", 128'({mem_req, busy}), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single main-memory port between the instruction cache and the data cache. It accepts line fills (on `cache_miss`) and dirty-line write-backs (on `write_to_memory`) from both caches. It runs one transaction at a time against memory with a req/ack handshake, then returns the result to the requesting cache as a one-cycle `from_memory_write_enable` or `completed_write_to_memory` pulse. It sits between the two cache instances and the memory model, at the top level of the processor.

## Interface
Parameters:
- `ADDR_SIZE`, default `PHYS_ADDR_SIZE`: physical address width.
- `LINE_WIDTH`, default `LINE_WIDTH`: cache line width in bits.

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `i_cache_miss`, `i_write_to_memory`  in  1  I-cache fill and write-back requests (level).
- `i_address`  in  ADDR_SIZE  I-cache `to_memory_address`.
- `i_out_data`  in  LINE_WIDTH  I-cache `to_memory_out_data`.
- `d_cache_miss`, `d_write_to_memory`, `d_address`, `d_out_data`: the same four ports for the D-cache.
- `i_from_memory_write_enable`, `d_from_memory_write_enable`  out  1  fill-done pulse, one per cache.
- `i_completed_write_to_memory`, `d_completed_write_to_memory`  out  1  write-back-done pulse, one per cache.
- `from_memory_input_data`  out  LINE_WIDTH  fill data, shared by both caches.
- `mem_req`  out  1  memory request, held until ack.
- `mem_write`  out  1  1 = write-back, 0 = fill.
- `mem_addr`  out  ADDR_SIZE  line address.
- `mem_wdata`  out  LINE_WIDTH  write-back data.
- `mem_ack`  in  1  memory done; one-cycle pulse, only while `mem_req` is high.
- `mem_rdata`  in  LINE_WIDTH  fill data, valid in the `mem_ack` cycle.
- `busy`  out  1  high while the FSM is not in IDLE.

## Operation
- Per-cache request: `req_x = x_cache_miss | x_write_to_memory`. A cache never asserts both, so `mem_write = x_write_to_memory` at grant.
- FSM states:
  - **IDLE**: if any `req_x`, pick a winner, latch its address, data and `mem_write`, and record the grant. Go to MEM.
  - **MEM**: hold `mem_req=1` with stable `mem_addr`, `mem_wdata` and `mem_write`. On `mem_ack`, capture `mem_rdata` (fills only) and go to DONE.
  - **DONE**: pulse exactly one output of the granted cache, then go to IDLE. Fills pulse `x_from_memory_write_enable` with `from_memory_input_data` = captured line. Write-backs pulse `x_completed_write_to_memory`.
- Arbitration is round-robin. On a tie, the cache not granted last wins. `last_grant` updates at each grant.
- All request inputs are ignored outside IDLE. A request withdrawn during MEM still completes and still pulses; the cache discards it.
- The pulse lands while the cache's request is still high. The cache clears its request at that edge, so IDLE never re-grants the same request.
- A write-back followed by a fill of the same line is two separate grants. The other cache may win in between.
- Reset values:
  - State IDLE, `last_grant` = D, so the I-cache wins the first tie.
  - All outputs 0, including `from_memory_input_data` and `busy`.
  - Reset asserted mid-transaction drops `mem_req` immediately and aborts; no pulse is issued.

## Timing
- All outputs are registered.
- Request visible in cycle 0 → `mem_req` high from cycle 1.
- `mem_ack` in cycle k (k ≥ 1) → `mem_req` low and done pulse high in cycle k+1 → IDLE in k+2 → next grant's `mem_req` in k+3.
- Minimum occupancy is 3 cycles per transaction. `from_memory_input_data` holds the last fill until the next fill.

## Configuration
- `MEM_ARB_DCACHE_PRIORITY_EN`:
  - Defined: fixed priority, D-cache always wins a tie, and `last_grant` is unused.
  - Undefined (default): round-robin as above.

## Structure
- Shared package `mem_arb_pkg` holds:
  - the state encoding (IDLE, MEM, DONE);
  - port indices `PORT_I=0`, `PORT_D=1`.
- Sub-module `mem_arb_picker` is combinational. Inputs: two request bits and `last_grant`. Output: the grant index. The macro selects its policy.

## Test plan
- Single I fill: `i_cache_miss=1`, `i_address=0x1000`, ack after 3 cycles with rdata `0xCAFE` → `mem_addr=0x1000`, `mem_write=0`, then one-cycle `i_from_memory_write_enable` with data `0xCAFE`.
- D write-back then fill: `d_write_to_memory=1`, `d_out_data=0xBEEF` → `mem_write=1` with wdata `0xBEEF`, then `d_completed_write_to_memory` pulse. Next, `d_cache_miss` → a separate fill grant.
- Simultaneous requests from reset: I granted first, then D. Repeat with both held → grants alternate I, D, I, D. With the macro: D, D, ….
- Back-to-back: ack the same cycle `mem_req` rises → pulse the next cycle; the other cache's request is granted 3 cycles after its predecessor.
- Request dropped during MEM → the transaction still completes and the pulse still fires; no second grant follows.
- `reset_n` low during MEM → `mem_req` is 0 immediately, no pulse, `busy=0`; after release, a fresh request is granted normally.
